sample_tick_divider: RTL and testbench



---
 rtl/freq_div_pkg.sv | 20 ++
 rtl/modulo_counter.sv | 59 +++++
 rtl/sample_tick_divider.sv | 87 ++++++++
 tb/tb_sample_tick_divider.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/freq_div_pkg.sv
// Shared divisor types and constants for the key-driven divisor
// generator and the sample tick divider.
package freq_div_pkg;

    localparam int DIVISOR_W = 32;

    typedef logic [DIVISOR_W-1:0] divisor_t;

    localparam divisor_t MIN_DIVISOR_DEF     = 32'd2;
    localparam divisor_t DEFAULT_DIVISOR_DEF = 32'd1136;

    // Clamp a requested divisor up to the floor; nothing else is applied.
    function automatic divisor_t sat_divisor(
        input divisor_t d,
        input divisor_t floor_v
    );
        return (d < floor_v) ? floor_v : d;
    endfunction

endpackage

// File: rtl/modulo_counter.sv
// Period counter: counts enabled edges 0..period-1 and reloads the period
// from load_val at each wrap or on restart.
// Ports: clk, reset_n (async, active-low), enable, restart,
//        load_val (next period), count, period (active), wrap (boundary).
module modulo_counter
    import freq_div_pkg::*;
#(
    parameter divisor_t RESET_PERIOD = DEFAULT_DIVISOR_DEF
) (
    input  logic     clk,
    input  logic     reset_n,
    input  logic     enable,
    input  logic     restart,
    input  divisor_t load_val,
    output divisor_t count,
    output divisor_t period,
    output logic     wrap
);

    divisor_t count_q;
    divisor_t count_d;
    divisor_t period_q;
    divisor_t period_d;
    logic     at_end;

    // restart masks the boundary so it always wins over a tick
    always_comb begin
        at_end = (count_q == (period_q - divisor_t'(1)));
        wrap   = enable & ~restart & at_end;
    end

    always_comb begin
        count_d  = count_q;
        period_d = period_q;
        if (restart) begin
            count_d  = '0;
            period_d = load_val;
        end else if (wrap) begin
            count_d  = '0;
            period_d = load_val;
        end else if (enable) begin
            count_d  = count_q + divisor_t'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q  <= '0;
            period_q <= RESET_PERIOD;
        end else begin
            count_q  <= count_d;
            period_q <= period_d;
        end
    end

    assign count  = count_q;
    assign period = period_q;

endmodule

// File: rtl/sample_tick_divider.sv
// Turns the divisor into a one-cycle sample tick, latching new divisors
// only at period boundaries. Optional square wave: SAMPLE_TICK_SQUARE_OUT_EN.
// Ports: clk, reset_n (async, active-low), enable, restart,
//        frequency_divisor in; tick, clk_out, period out.
module sample_tick_divider
    import freq_div_pkg::*;
#(
    parameter divisor_t DEFAULT_DIVISOR = DEFAULT_DIVISOR_DEF,
    parameter divisor_t MIN_DIVISOR     = MIN_DIVISOR_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic        restart,
    input  logic [31:0] frequency_divisor,
    output logic        tick,
    output logic        clk_out,
    output logic [31:0] period
);

    localparam divisor_t RESET_PERIOD =
        sat_divisor(DEFAULT_DIVISOR, MIN_DIVISOR);

    divisor_t load_val;
    divisor_t count;
    logic     wrap;
    logic     tick_q;
    logic     tick_d;

    always_comb begin
        load_val = sat_divisor(frequency_divisor, MIN_DIVISOR);
    end

    modulo_counter #(
        .RESET_PERIOD (RESET_PERIOD)
    ) u_counter (
        .clk      (clk),
        .reset_n  (reset_n),
        .enable   (enable),
        .restart  (restart),
        .load_val (load_val),
        .count    (count),
        .period   (period),
        .wrap     (wrap)
    );

    // wrap already excludes restart and disabled edges
    always_comb begin
        tick_d = wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

`ifdef SAMPLE_TICK_SQUARE_OUT_EN
    logic clk_out_q;
    logic clk_out_d;

    always_comb begin
        clk_out_d = clk_out_q ^ wrap;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_out_q <= 1'b0;
        end else begin
            clk_out_q <= clk_out_d;
        end
    end

    assign clk_out = clk_out_q;
`else
    assign clk_out = 1'b0;
`endif

    // count is internal state; only its boundary matters here
    logic unused_count;
    assign unused_count = ^count;

endmodule

// File: tb/tb_sample_tick_divider.sv
// Randomized + directed bench for sample_tick_divider against a
// countdown-based behavioural model.
module tb_sample_tick_divider;

    logic        clk;
    logic        reset_n;
    logic        enable;
    logic        restart;
    logic [31:0] frequency_divisor;
    logic        tick;
    logic        clk_out;
    logic [31:0] period;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc;

    // model state: active period, enabled edges left until the tick
    int unsigned m_per;
    int unsigned m_rem;
    logic        m_tick;
    logic        m_clk;

    sample_tick_divider dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .enable            (enable),
        .restart           (restart),
        .frequency_divisor (frequency_divisor),
        .tick              (tick),
        .clk_out           (clk_out),
        .period            (period)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int unsigned sat(input logic [31:0] d);
        return (d < 32'd2) ? 32'd2 : d;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc = 0;
        else cyc = cyc + 1;
    end

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_per  = 1136;
            m_rem  = 1136;
            m_tick = 1'b0;
            m_clk  = 1'b0;
        end else if (restart) begin
            m_per  = sat(frequency_divisor);
            m_rem  = m_per;
            m_tick = 1'b0;
        end else if (!enable) begin
            m_tick = 1'b0;
        end else begin
            m_rem = m_rem - 1;
            if (m_rem == 0) begin
                m_tick = 1'b1;
`ifdef SAMPLE_TICK_SQUARE_OUT_EN
                m_clk  = ~m_clk;
`endif
                m_per  = sat(frequency_divisor);
                m_rem  = m_per;
            end else begin
                m_tick = 1'b0;
            end
        end
    end

    task automatic check(input string name,
                         input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp = n_cmp + 1;
        if (act !== exp) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected %0d (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (reset_n) begin
            check("tick", {31'd0, tick}, {31'd0, m_tick});
            check("clk_out", {31'd0, clk_out}, {31'd0, m_clk});
            check("period", period, m_per);
        end
    end

    task automatic wait_tick(output int at);
        at = -1;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (tick) begin
                at = cyc;
                return;
            end
        end
        check("tick_timeout", 32'd0, 32'd1);
    endtask

    task automatic do_restart(input logic [31:0] d, output int r);
        frequency_divisor = d;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        r = cyc;
    endtask

    int r, t, t2, a, b;
    logic c1, c2;

    initial begin
        reset_n = 1'b0;
        enable  = 1'b1;
        restart = 1'b0;
        frequency_divisor = 32'd1136;
        #12;
        check("rst_tick", {31'd0, tick}, 32'd0);
        check("rst_period", period, 32'd1136);
        check("rst_clk_out", {31'd0, clk_out}, 32'd0);
        check("model_rst_period", m_per, 32'd1136);
        @(negedge clk);
        reset_n = 1'b1;

        // default period from reset
        wait_tick(t);
        check("first_tick_edge", t, 1136);
        wait_tick(t);
        check("second_tick_edge", t, 2272);

        // divisor change mid-period takes effect after current period
        do_restart(32'd10, r);
        repeat (3) @(negedge clk);
        frequency_divisor = 32'd4;
        wait_tick(t);
        check("old_period_10", t - r, 10);
        wait_tick(a);
        check("new_period_4", a - t, 4);
        wait_tick(b);
        check("new_period_4b", b - a, 4);

        // clamping of 0 and 1
        do_restart(32'd0, r);
        check("clamp0_period", period, 32'd2);
        wait_tick(a);
        wait_tick(b);
        check("clamp0_first", a - r, 2);
        check("clamp0_spacing", b - a, 2);
        do_restart(32'd1, r);
        check("clamp1_period", period, 32'd2);
        wait_tick(a);
        @(negedge clk);
        check("clamp1_high_one", {31'd0, tick}, 32'd0);
        wait_tick(b);
        check("clamp1_spacing", b - a, 2);

        // enable low mid-period delays the tick
        do_restart(32'd8, r);
        repeat (3) @(negedge clk);
        enable = 1'b0;
        repeat (5) @(negedge clk);
        enable = 1'b1;
        wait_tick(t);
        check("en_low_delay", t - r, 13);

        // enable low exactly on boundary edge
        repeat (7) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        check("en_low_boundary_no_tick", {31'd0, tick}, 32'd0);
        enable = 1'b1;
        wait_tick(t2);
        check("en_low_boundary_tick", t2 - t, 9);
        @(negedge clk);
        check("en_low_no_dup", {31'd0, tick}, 32'd0);

        // restart on the boundary edge wins
        repeat (6) @(negedge clk);
        frequency_divisor = 32'd8;
        do_restart(32'd8, r);
        check("restart_boundary_no_tick", {31'd0, tick}, 32'd0);
        wait_tick(t);
        check("restart_next_tick", t - r, 8);

        // async reset mid-period
        repeat (5) @(negedge clk);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_rst_period", period, 32'd1136);
        check("async_rst_tick", {31'd0, tick}, 32'd0);
        check("async_rst_clk_out", {31'd0, clk_out}, 32'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // square wave
        do_restart(32'd6, r);
        wait_tick(a);
        c1 = clk_out;
        wait_tick(b);
        c2 = clk_out;
        check("sq_spacing", b - a, 6);
`ifdef SAMPLE_TICK_SQUARE_OUT_EN
        check("sq_toggle", {31'd0, c2}, {31'd0, ~c1});
`else
        check("sq_tied_a", {31'd0, c1}, 32'd0);
        check("sq_tied_b", {31'd0, c2}, 32'd0);
`endif

        // random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            enable  = ($urandom_range(0, 9) != 0);
            restart = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 19) == 0)
                frequency_divisor = $urandom_range(0, 20);
        end
        restart = 1'b0;
        enable  = 1'b1;
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
